qu_run_ctrl: RTL



---
 rtl/qu_common.sv | 15 +
 rtl/qu_run_ctrl_if.sv | 47 ++++
 rtl/qu_sat_counter.sv | 23 ++
 rtl/qu_run_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/qu_common.sv
// rtl/qu_common.sv - shared Qu types and constants used by the run controller
package qu_common;

    localparam int PHY_RF_ADDR_WIDTH = 6;
    localparam int QU_RUN_DONE_ADDR  = 10;
    localparam int QU_RUN_PASS_VALUE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_t;

endpackage

// File: rtl/qu_run_ctrl_if.sv
// rtl/qu_run_ctrl_if.sv - run controller signal bundle with master/slave views
// master: bench/debug side (drives start, stall_req, monitored RF write; observes status)
// slave : qu_run_ctrl side
// Optional QU_RUN_CTRL_STALL_CNT_EN adds stall_cnt[NUM_STALL_CH].
interface qu_run_ctrl_if #(
    parameter int NUM_STALL_CH = 3,
    parameter int CNT_WIDTH    = 32
) ();
    import qu_common::*;

    logic                         start;
    logic [NUM_STALL_CH-1:0]      stall_req;
    logic                         rf_wr_en;
    logic [PHY_RF_ADDR_WIDTH-1:0] rf_rd_addr;
    logic [31:0]                  rf_data_in;

    logic                         core_rst;
    logic [NUM_STALL_CH-1:0]      stall_out;
    logic                         done;
    logic                         pass;
    logic                         timeout;
    logic [CNT_WIDTH-1:0]         cycle_count;
    run_state_t                   state;

`ifdef QU_RUN_CTRL_STALL_CNT_EN
    logic [CNT_WIDTH-1:0]         stall_cnt [NUM_STALL_CH];

    modport master (
        output start, stall_req, rf_wr_en, rf_rd_addr, rf_data_in,
        input  core_rst, stall_out, done, pass, timeout, cycle_count, state, stall_cnt
    );
    modport slave (
        input  start, stall_req, rf_wr_en, rf_rd_addr, rf_data_in,
        output core_rst, stall_out, done, pass, timeout, cycle_count, state, stall_cnt
    );
`else
    modport master (
        output start, stall_req, rf_wr_en, rf_rd_addr, rf_data_in,
        input  core_rst, stall_out, done, pass, timeout, cycle_count, state
    );
    modport slave (
        input  start, stall_req, rf_wr_en, rf_rd_addr, rf_data_in,
        output core_rst, stall_out, done, pass, timeout, cycle_count, state
    );
`endif

endinterface

// File: rtl/qu_sat_counter.sv
// rtl/qu_sat_counter.sv - saturating up-counter with synchronous clear and enable
// clk, rst (async active-high), clr (priority over en), en, count[WIDTH]
module qu_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/qu_run_ctrl.sv
// rtl/qu_run_ctrl.sv - Qu core run controller: reset pulse, stall gating, end-of-test, watchdog
// clk, rst (async active-high), bus (qu_run_ctrl_if.slave): start, stall_req, rf_wr_en,
// rf_rd_addr, rf_data_in in; core_rst, stall_out, done, pass, timeout, cycle_count, state out.
// Optional QU_RUN_CTRL_STALL_CNT_EN: per-channel stall_cnt counters on the bus.
module qu_run_ctrl
    import qu_common::*;
#(
    parameter int RST_CYCLES     = 5,
    parameter int TIMEOUT_CYCLES = 20,
    parameter int NUM_STALL_CH   = 3,
    parameter int CNT_WIDTH      = 32,
    parameter int DONE_ADDR      = QU_RUN_DONE_ADDR,
    parameter int PASS_VALUE     = QU_RUN_PASS_VALUE
) (
    input  logic          clk,
    input  logic          rst,
    qu_run_ctrl_if.slave  bus
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0]                RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]         WD_LAST   =
        CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [PHY_RF_ADDR_WIDTH-1:0] END_ADDR  = PHY_RF_ADDR_WIDTH'(DONE_ADDR);
    localparam logic [31:0]                  PASS_WORD = 32'(PASS_VALUE);

    run_state_t              state_q;
    logic [RW-1:0]           rst_cnt;
    logic                    core_rst_q;
    logic [NUM_STALL_CH-1:0] stall_q;
    logic                    done_q;
    logic                    pass_q;
    logic                    timeout_q;
    logic [CNT_WIDTH-1:0]    cycle_cnt;

    logic restart;
    logic end_wr;
    logic wd_fire;

    assign restart = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign end_wr  = (state_q == ST_RUN) && bus.rf_wr_en && (bus.rf_rd_addr == END_ADDR);
    assign wd_fire = (state_q == ST_RUN) && (TIMEOUT_CYCLES != 0) && (cycle_cnt == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rst_cnt    <= '0;
            core_rst_q <= 1'b1;
            stall_q    <= '1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q    <= ST_RESET;
                        rst_cnt    <= '0;
                        core_rst_q <= 1'b1;
                        stall_q    <= '1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        timeout_q  <= 1'b0;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state_q    <= ST_RUN;
                        core_rst_q <= 1'b0;
                        // First RUN cycle already sees the request sampled one cycle earlier.
                        stall_q    <= bus.stall_req;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    // End-write is checked first so it beats a coincident watchdog expiry.
                    if (end_wr) begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        pass_q    <= (bus.rf_data_in == PASS_WORD);
                        timeout_q <= 1'b0;
                        stall_q   <= '1;
                    end else if (wd_fire) begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        stall_q   <= '1;
                    end else begin
                        stall_q <= bus.stall_req;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    qu_sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (restart),
        .en    (state_q == ST_RUN),
        .count (cycle_cnt)
    );

`ifdef QU_RUN_CTRL_STALL_CNT_EN
    for (genvar g = 0; g < NUM_STALL_CH; g++) begin : g_stall_cnt
        qu_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (restart),
            .en    ((state_q == ST_RUN) && stall_q[g]),
            .count (bus.stall_cnt[g])
        );
    end
`endif

    assign bus.state       = state_q;
    assign bus.core_rst    = core_rst_q;
    assign bus.stall_out   = stall_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cycle_cnt;

endmodule
